// File: rtl/struct_pkg.sv
// Shared layout of the packed struct word used by both the packer and the unpacker.
package struct_pkg;

    localparam int BYTE_W    = 8;
    localparam int TAIL_W    = 15;
    localparam int NUM_BYTES = 25;
    localparam int WORD_W    = NUM_BYTES * BYTE_W + TAIL_W;
    localparam int FLD_W     = (BYTE_W > TAIL_W) ? BYTE_W : TAIL_W;
    localparam int IDX_W     = $clog2(NUM_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        TAIL
    } unpack_state_t;

    // MSB bit position of field i within the flat word; i == NUM_BYTES is the tail field
    function automatic int fld_msb(input int i);
        return (i < NUM_BYTES) ? (WORD_W - 1 - i * BYTE_W) : (TAIL_W - 1);
    endfunction

endpackage

// File: rtl/struct_csum_acc.sv
// Byte checksum accumulator: clear / add-byte / hold, sum wraps mod 2^BYTE_W.
// Latency: sum reflects an add on the cycle after it is requested.
// Backpressure: none; the caller only asserts add on accepted beats.
module struct_csum_acc
    import struct_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [BYTE_W-1:0] sum
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + byte_in;
        end
    end

endmodule

// File: rtl/struct_unpacker.sv
// Streams one packed struct word out as NUM_BYTES byte beats plus one tail beat with index/last/checksum.
// Latency: first beat valid the cycle after the word is accepted; one idle cycle between words.
// Backpressure: out_ready low freezes the stream with outputs held; in_ready low while a word is in flight.
module struct_unpacker
    import struct_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FLD_W-1:0]  out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic [BYTE_W-1:0] out_csum
);

    unpack_state_t     state_q, state_d;
    logic [WORD_W-1:0] shadow_q;
    logic [IDX_W-1:0]  idx_q;
    logic [BYTE_W-1:0] csum;
    logic              csum_clr;
    logic              csum_add;
    logic [BYTE_W-1:0] head_byte;
    logic [TAIL_W-1:0] head_tail;

    // Shadow is shifted left per byte beat, so the current field always sits at the top
    assign head_byte = shadow_q[fld_msb(0) -: BYTE_W];
    assign head_tail = shadow_q[fld_msb(0) -: TAIL_W];

    struct_csum_acc u_csum (
        .clk     (clk),
        .rst     (rst),
        .clr     (csum_clr),
        .add     (csum_add),
        .byte_in (head_byte),
        .sum     (csum)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        out_csum  = '0;
        csum_clr  = 1'b0;
        csum_add  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d  = EMIT;
                    csum_clr = 1'b1;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_data  = FLD_W'(head_byte);
                out_idx   = idx_q;
                if (out_ready) begin
                    csum_add = 1'b1;
                    if (idx_q == IDX_W'(NUM_BYTES - 1)) begin
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                out_valid = 1'b1;
                out_data  = FLD_W'(head_tail);
                out_idx   = IDX_W'(NUM_BYTES);
                out_last  = 1'b1;
                out_csum  = csum;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                shadow_q <= in_word;
                idx_q    <= '0;
            end else if (state_q == EMIT && out_ready) begin
                shadow_q <= {shadow_q[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                idx_q    <= idx_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_struct_unpacker.sv
// Randomised bench for struct_unpacker against a field-list reference model.
module tb_struct_unpacker;
    import struct_pkg::*;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              out_valid;
    logic              out_ready;
    logic [FLD_W-1:0]  out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic [BYTE_W-1:0] out_csum;

    struct_unpacker dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_csum  (out_csum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rdy_mode = 0;           // 0: always ready, 1: random 50%, 2: held low
    int n_acc = 0;
    int n_tail = 0;
    int last_tail_cyc = -100;
    int acc_gap = 0;
    logic [BYTE_W-1:0] last_csum = '0;

    // beat = {valid, data, idx, last, csum}
    logic [29:0] exp_q[$];
    logic [29:0] cur_beat;
    logic [29:0] held_beat;
    logic        stall_prev = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_push(input logic [WORD_W-1:0] w);
        int sum = 0;
        logic [WORD_W-1:0] t;
        logic [7:0] b;
        logic [14:0] tl;
        for (int i = 0; i < 25; i++) begin
            t = w >> (215 - 8 * (i + 1));
            b = t[7:0];
            sum = sum + int'(b);
            exp_q.push_back({1'b1, 7'd0, b, 5'(i), 1'b0, 8'd0});
        end
        tl = w[14:0];
        exp_q.push_back({1'b1, tl, 5'd25, 1'b1, 8'(sum % 256)});
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
            else               out_ready = (rdy_mode == 0);
        end
    end

    always @(negedge clk) begin
        cur_beat = {out_valid, out_data, out_idx, out_last, out_csum};
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                acc_gap = cyc - last_tail_cyc;
                n_acc++;
                model_push(in_word);
            end
            if (stall_prev) check_val("stable", 64'(cur_beat), 64'(held_beat));
            if (out_valid) check_val("busy_rdy", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_beat", 64'(cur_beat), 64'd0);
                end else begin
                    check_val("beat", 64'(cur_beat), 64'(exp_q.pop_front()));
                end
                if (out_last) begin
                    n_tail++;
                    last_tail_cyc = cyc;
                    last_csum = out_csum;
                end
            end
            stall_prev = out_valid && !out_ready;
            held_beat = cur_beat;
        end
    end

    task automatic send(input logic [WORD_W-1:0] w);
        int t = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_word  = w;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 1000);
        if (!in_ready) check_val("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        check_val("drain", 64'(exp_q.size() == 0 && !out_valid), 64'd1);
    endtask

    function automatic logic [WORD_W-1:0] rand_word();
        logic [223:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[WORD_W-1:0];
    endfunction

    logic [WORD_W-1:0] w_cnt;
    logic [WORD_W-1:0] w_b;
    int tails0;
    int t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_word = '0;
        out_ready = 1'b1;
        w_cnt = '0;
        for (int i = 0; i < 25; i++) w_cnt = (w_cnt << 8) | WORD_W'(25 - i);
        w_cnt = w_cnt << 15;

        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_data", 64'(out_data), 64'd0);
        check_val("rst_out_idx", 64'(out_idx), 64'd0);
        check_val("rst_out_last", 64'(out_last), 64'd0);
        check_val("rst_out_csum", 64'(out_csum), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // counting word, always ready
        send(w_cnt);
        drain(200);
        check_val("csum_count", 64'(last_csum), 64'h45);

        // all ones: checks checksum wrap and full tail
        send('1);
        drain(200);
        check_val("csum_ones", 64'(last_csum), 64'hE7);

        // same counting word under random backpressure
        rdy_mode = 1;
        send(w_cnt);
        drain(2000);
        check_val("csum_count_bp", 64'(last_csum), 64'h45);
        rdy_mode = 0;

        // in_valid held high over two words
        w_b = rand_word();
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_word  = w_cnt;
        tails0 = n_acc;
        t = 0;
        while (n_acc == tails0 && t < 200) begin @(negedge clk); #1; t++; end
        @(posedge clk);
        #1;
        in_word = w_b;
        t = 0;
        while (n_acc == tails0 + 1 && t < 200) begin @(negedge clk); #1; t++; end
        check_val("second_accepted", 64'(n_acc - tails0), 64'd2);
        check_val("accept_gap", 64'(acc_gap), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain(200);

        // reset in the middle of beat 10
        send(w_cnt);
        t = 0;
        while (!(out_valid && out_idx == 5'd10) && t < 200) begin @(negedge clk); #1; t++; end
        tails0 = n_tail;
        rst = 1'b1;
        #1;
        check_val("midrst_out_valid", 64'(out_valid), 64'd0);
        check_val("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        check_val("midrst_no_tail", 64'(n_tail), 64'(tails0));
        send(w_cnt);
        drain(200);
        check_val("csum_after_rst", 64'(last_csum), 64'h45);

        // long stall on the tail beat
        tails0 = n_tail;
        send(w_b);
        t = 0;
        while (!(out_valid && out_idx == 5'd24) && t < 200) begin @(negedge clk); #1; t++; end
        rdy_mode = 2;
        repeat (100) @(negedge clk);
        #1;
        check_val("stall_last", 64'({out_valid, out_last}), 64'd3);
        check_val("stall_no_hs", 64'(n_tail), 64'(tails0));
        rdy_mode = 0;
        drain(200);
        check_val("stall_one_hs", 64'(n_tail - tails0), 64'd1);

        // random words under random backpressure
        rdy_mode = 1;
        for (int k = 0; k < 6; k++) begin
            send(rand_word());
            drain(2000);
        end
        rdy_mode = 0;

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
